// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants, next-PC select encoding and the PC alignment helper for the fetch PC generator.
package fetch_pc_gen_pkg;

    localparam int          PC_W             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    typedef enum logic [2:0] {
        NPC_RESET = 3'd0,
        NPC_REDIR = 3'd1,
        NPC_HOLD  = 3'd2,
        NPC_PRED  = 3'd3,
        NPC_SEQ   = 3'd4
    } npc_sel_e;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Redirect event counters; compiled in only when FETCH_PERF_EN is defined, otherwise outputs read 0.
module fetch_perf_counters
    import fetch_pc_gen_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_inc,
    input  logic            flush_inc,
    output logic [PC_W-1:0] perf_pred_redir,
    output logic [PC_W-1:0] perf_flush_redir
);

`ifdef FETCH_PERF_EN
    logic [31:0] pred_cnt_r;
    logic [31:0] flush_cnt_r;

    // Free-running wrapping event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_cnt_r  <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (pred_inc) begin
                pred_cnt_r <= pred_cnt_r + 32'd1;
            end
            if (flush_inc) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign perf_pred_redir  = pred_cnt_r;
    assign perf_flush_redir = flush_cnt_r;
`else
    logic unused_inputs_s;
    assign unused_inputs_s  = ^{clk, rst, pred_inc, flush_inc};
    assign perf_pred_redir  = 32'd0;
    assign perf_flush_redir = 32'd0;
`endif

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with IF/ID/EX prediction handoff; optional perf counters under FETCH_PERF_EN.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_stall,
    input  logic [PC_W-1:0] id_target,
    input  logic            id_target_taken,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_target,
    output logic [PC_W-1:0] if_addr,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid,
    output logic            ex_pred_taken,
    output logic [PC_W-1:0] ex_pred_target,
    output logic [PC_W-1:0] perf_pred_redir,
    output logic [PC_W-1:0] perf_flush_redir
);

    npc_sel_e        npc_sel_s;
    logic [PC_W-1:0] next_pc_s;
    logic            pred_redir_s;
    logic            pred_hit_s;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] id_pc_r;
    logic            id_valid_r;
    logic            ex_pred_taken_r;
    logic [PC_W-1:0] ex_pred_target_r;

    assign pred_hit_s = id_valid_r & id_target_taken;

    // Next-PC source selection in strict priority order
    always_comb begin
        npc_sel_s = NPC_SEQ;
        if (rst) begin
            npc_sel_s = NPC_RESET;
        end else if (redir_valid) begin
            npc_sel_s = NPC_REDIR;
        end else if (id_stall) begin
            npc_sel_s = NPC_HOLD;
        end else if (pred_hit_s) begin
            npc_sel_s = NPC_PRED;
        end else begin
            npc_sel_s = NPC_SEQ;
        end
    end

    assign pred_redir_s = (npc_sel_s == NPC_PRED);

    // Next-PC value mux; every loaded PC is word aligned
    always_comb begin
        next_pc_s = pc_r;
        case (npc_sel_s)
            NPC_RESET: next_pc_s = align_pc(RESET_PC);
            NPC_REDIR: next_pc_s = align_pc(redir_target);
            NPC_HOLD:  next_pc_s = pc_r;
            NPC_PRED:  next_pc_s = align_pc(id_target);
            NPC_SEQ:   next_pc_s = align_pc(pc_r + INSTR_BYTES);
            default:   next_pc_s = align_pc(RESET_PC);
        endcase
    end

    // PC register
    always_ff @(posedge clk) begin
        pc_r <= next_pc_s;
    end

    // IF->ID handoff; redirects squash the fetch in flight even when stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc_r    <= 32'd0;
            id_valid_r <= 1'b0;
        end else if (redir_valid) begin
            id_valid_r <= 1'b0;
            if (!id_stall) begin
                id_pc_r <= pc_r;
            end
        end else if (!id_stall) begin
            id_pc_r    <= pc_r;
            id_valid_r <= ~pred_hit_s;
        end
    end

    // ID->EX prediction handoff; a back-end redirect always drops the carried prediction
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_pred_taken_r  <= 1'b0;
            ex_pred_target_r <= 32'd0;
        end else begin
            if (!id_stall) begin
                ex_pred_target_r <= id_target;
            end
            if (redir_valid) begin
                ex_pred_taken_r <= 1'b0;
            end else if (!id_stall) begin
                ex_pred_taken_r <= pred_hit_s;
            end
        end
    end

    assign if_addr        = pc_r;
    assign id_pc          = id_pc_r;
    assign id_valid       = id_valid_r;
    assign ex_pred_taken  = ex_pred_taken_r;
    assign ex_pred_target = ex_pred_target_r;

    fetch_perf_counters u_perf (
        .clk              (clk),
        .rst              (rst),
        .pred_inc         (pred_redir_s),
        .flush_inc        (redir_valid & ~rst),
        .perf_pred_redir  (perf_pred_redir),
        .perf_flush_redir (perf_flush_redir)
    );

endmodule
